pkt_write_ctrl: RTL and testbench

PKT_WRITE_CTRL -- requirements
Module: pkt_write_ctrl

---
 rtl/pkt_write_ctrl.sv | 153 +++++++++++++++
 tb/tb_pkt_write_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_write_ctrl.sv
// Packet framer in front of a commit/rollback FIFO: SOF, LEN, payload, CSUM.
// Optional inter-byte gap timeout is compiled in with macro PKT_TIMEOUT_EN.
module pkt_write_ctrl #(
    parameter logic [7:0]  SOF_BYTE = 8'hA5,
    parameter int          MAX_LEN  = 64,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic        writeClk,
    input  logic        reset,
    input  logic        rxValid,
    input  logic [7:0]  rxData,
    input  logic        rxFrameErr,
    input  logic        almostFull,
    output logic [8:0]  fifoDataIn,
    output logic        fifoWriteEn,
    output logic        fifoCommit,
    output logic        fifoRollback,
    output logic        busy,
    output logic [15:0] okCount,
    output logic [15:0] dropCount
);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, COMMIT, DROP} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state, stateNext;
    logic [7:0] remaining, remainingNext;
    logic [7:0] sum, sumNext;
    logic [7:0] csumTotal;
    logic [8:0] dataNext;
    logic       writeNext, commitNext, rollbackNext;
    logic       okInc, dropInc;
    logic       inPacket;
    logic       gapHit;

    assign inPacket = (state == LEN) || (state == PAYLOAD) || (state == CSUM);

`ifdef PKT_TIMEOUT_EN
    logic [15:0] gapCount;

    always_ff @(posedge writeClk) begin
        if (reset || rxValid || !inPacket) begin
            gapCount <= 16'd0;
        end else begin
            gapCount <= gapCount + 16'd1;
        end
    end

    // Fires on the cycle whose edge would bring the gap to TIMEOUT.
    assign gapHit = inPacket && !rxValid && (gapCount == TIMEOUT - 16'd1);
`else
    assign gapHit = 1'b0;
`endif

    always_comb begin
        stateNext     = state;
        remainingNext = remaining;
        sumNext       = sum;
        dataNext      = fifoDataIn;
        writeNext     = 1'b0;
        commitNext    = 1'b0;
        rollbackNext  = 1'b0;
        okInc         = 1'b0;
        dropInc       = 1'b0;
        csumTotal     = sum + rxData;

        case (state)
            IDLE: begin
                if (rxValid && !rxFrameErr && rxData == SOF_BYTE) begin
                    stateNext = LEN;
                end
            end
            LEN: begin
                // Nothing has been written yet, so a drop here never rolls back.
                if (gapHit || (rxValid && rxFrameErr)) begin
                    stateNext = DROP;
                    dropInc   = 1'b1;
                end else if (rxValid) begin
                    if (rxData == 8'd0 || rxData > MAX_LEN_B) begin
                        stateNext = IDLE;
                        dropInc   = 1'b1;
                    end else begin
                        remainingNext = rxData;
                        sumNext       = rxData;
                        stateNext     = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (gapHit || (rxValid && (rxFrameErr || almostFull))) begin
                    stateNext    = DROP;
                    rollbackNext = 1'b1;
                    dropInc      = 1'b1;
                end else if (rxValid) begin
                    writeNext     = 1'b1;
                    dataNext      = {remaining == 8'd1, rxData};
                    sumNext       = sum + rxData;
                    remainingNext = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        stateNext = CSUM;
                    end
                end
            end
            CSUM: begin
                if (gapHit || (rxValid && (rxFrameErr || csumTotal != 8'd0))) begin
                    stateNext    = DROP;
                    rollbackNext = 1'b1;
                    dropInc      = 1'b1;
                end else if (rxValid) begin
                    stateNext  = COMMIT;
                    commitNext = 1'b1;
                    okInc      = 1'b1;
                end
            end
            COMMIT:  stateNext = IDLE;
            DROP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Strobes are decided on the transition, so they line up with the COMMIT/DROP cycle.
    always_ff @(posedge writeClk) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= 8'd0;
            sum          <= 8'd0;
            fifoDataIn   <= 9'd0;
            fifoWriteEn  <= 1'b0;
            fifoCommit   <= 1'b0;
            fifoRollback <= 1'b0;
            busy         <= 1'b0;
            okCount      <= 16'd0;
            dropCount    <= 16'd0;
        end else begin
            state        <= stateNext;
            remaining    <= remainingNext;
            sum          <= sumNext;
            fifoDataIn   <= dataNext;
            fifoWriteEn  <= writeNext;
            fifoCommit   <= commitNext;
            fifoRollback <= rollbackNext;
            busy         <= (stateNext != IDLE);
            if (okInc && okCount != 16'hFFFF) begin
                okCount <= okCount + 16'd1;
            end
            if (dropInc && dropCount != 16'hFFFF) begin
                dropCount <= dropCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_write_ctrl.sv
// Self-checking bench for pkt_write_ctrl: packet vector table plus a FIFO-event scoreboard.
// Define PKT_TIMEOUT_EN to exercise the gap timeout with TIMEOUT=100.
module tb_pkt_write_ctrl;

`ifdef PKT_TIMEOUT_EN
    localparam logic [15:0] TB_TIMEOUT = 16'd100;
`else
    localparam logic [15:0] TB_TIMEOUT = 16'd50000;
`endif

    // Scoreboard event encoding: {kind, data}; kind 0=write, 1=commit, 2=rollback.
    localparam logic [10:0] EV_C = {2'd1, 9'd0};
    localparam logic [10:0] EV_R = {2'd2, 9'd0};
    localparam logic [10:0] EV_0 = 11'd0;

    logic        writeClk = 1'b0;
    logic        reset = 1'b1;
    logic        rxValid = 1'b0;
    logic [7:0]  rxData = 8'd0;
    logic        rxFrameErr = 1'b0;
    logic        almostFull = 1'b0;
    logic [8:0]  fifoDataIn;
    logic        fifoWriteEn, fifoCommit, fifoRollback, busy;
    logic [15:0] okCount, dropCount;

    pkt_write_ctrl #(.SOF_BYTE(8'hA5), .MAX_LEN(64), .TIMEOUT(TB_TIMEOUT)) dut (
        .writeClk(writeClk), .reset(reset), .rxValid(rxValid), .rxData(rxData),
        .rxFrameErr(rxFrameErr), .almostFull(almostFull), .fifoDataIn(fifoDataIn),
        .fifoWriteEn(fifoWriteEn), .fifoCommit(fifoCommit), .fifoRollback(fifoRollback),
        .busy(busy), .okCount(okCount), .dropCount(dropCount)
    );

    always #5 writeClk = ~writeClk;

    typedef struct {
        int          n;
        logic [7:0]  b [8];
        int          afIdx;
        int          feIdx;
        int          nexp;
        logic [10:0] ev [4];
        int          dOk;
        int          dDrop;
    } vec_t;

    localparam int NV = 11;
    vec_t        vecs [NV];
    logic [10:0] expQ [$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          lastRxCycle = 0;
    int          lastRollbackCycle = 0;
    int          rollbackSeen = 0;
    int          expOk = 0;
    int          expDrop = 0;

    always @(posedge writeClk) cycle <= cycle + 1;

    function automatic logic [10:0] wr(input logic [8:0] d);
        return {2'd0, d};
    endfunction

    function automatic vec_t mk(input int n, input logic [63:0] bytes, input int afIdx,
                                input int feIdx, input int nexp, input logic [43:0] evs,
                                input int dOk, input int dDrop);
        vec_t v;
        v.n = n; v.afIdx = afIdx; v.feIdx = feIdx; v.nexp = nexp; v.dOk = dOk; v.dDrop = dDrop;
        for (int i = 0; i < 8; i++) v.b[i] = bytes[63 - 8*i -: 8];
        for (int i = 0; i < 4; i++) v.ev[i] = evs[43 - 11*i -: 11];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic observe(input logic [10:0] got);
        logic [10:0] exp;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
            exp = expQ.pop_front();
            if (exp !== got) begin
                errors++;
                $display("FAIL event: got %h expected %h", got, exp);
            end
        end
    endtask

    always @(negedge writeClk) begin
        if (!reset) begin
            if (int'(fifoWriteEn) + int'(fifoCommit) + int'(fifoRollback) > 1) begin
                checks++;
                errors++;
                $display("FAIL strobe_exclusive: got %b%b%b expected one-hot",
                         fifoWriteEn, fifoCommit, fifoRollback);
            end
            if (fifoWriteEn) observe(wr(fifoDataIn));
            if (fifoCommit) observe(EV_C);
            if (fifoRollback) begin
                observe(EV_R);
                lastRollbackCycle = cycle;
                rollbackSeen++;
            end
        end
    end

    // Called #1 after a rising edge; leaves the bench #1 after a rising edge.
    task automatic sendByte(input logic [7:0] d, input logic fe, input logic af, input int gap);
        rxValid = 1'b1; rxData = d; rxFrameErr = fe; almostFull = af;
        @(posedge writeClk); #1;
        rxValid = 1'b0; rxFrameErr = 1'b0; almostFull = 1'b0;
        lastRxCycle = cycle;
        repeat (gap) begin @(posedge writeClk); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge writeClk); #1; end
    endtask

    task automatic checkSettled(input string tag);
        check({tag, "_okCount"}, 32'(okCount), 32'(expOk));
        check({tag, "_dropCount"}, 32'(dropCount), 32'(expDrop));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_queue_empty"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int startRb;
        int waited;
        vecs[0]  = mk(6, {8'hA5,8'h03,8'h01,8'h02,8'h03,8'hF7,16'h0}, -1, -1, 4,
                      {wr(9'h001), wr(9'h002), wr(9'h103), EV_C}, 1, 0);
        vecs[1]  = mk(6, {8'hA5,8'h03,8'h01,8'h02,8'h03,8'h00,16'h0}, -1, -1, 4,
                      {wr(9'h001), wr(9'h002), wr(9'h103), EV_R}, 0, 1);
        vecs[2]  = mk(4, {8'hA5,8'h03,8'h01,8'h02,32'h0}, 3, -1, 2,
                      {wr(9'h001), EV_R, EV_0, EV_0}, 0, 1);
        vecs[3]  = mk(2, {8'hA5,8'h00,48'h0}, -1, -1, 0, {4{EV_0}}, 0, 1);
        vecs[4]  = mk(2, {8'hA5,8'h41,48'h0}, -1, -1, 0, {4{EV_0}}, 0, 1);
        vecs[5]  = mk(6, {8'h00,8'h11,8'hA5,8'h01,8'h07,8'hF8,16'h0}, -1, -1, 2,
                      {wr(9'h107), EV_C, EV_0, EV_0}, 1, 0);
        vecs[6]  = mk(4, {8'hA5,8'h02,8'h10,8'h20,32'h0}, -1, 3, 2,
                      {wr(9'h010), EV_R, EV_0, EV_0}, 0, 1);
        vecs[7]  = mk(2, {8'hA5,8'h02,48'h0}, -1, 1, 0, {4{EV_0}}, 0, 1);
        vecs[8]  = mk(4, {8'hA5,8'h01,8'hFF,8'h00,32'h0}, -1, -1, 2,
                      {wr(9'h1FF), EV_C, EV_0, EV_0}, 1, 0);
        vecs[9]  = mk(5, {8'hA5,8'h02,8'h10,8'h20,8'hCE,24'h0}, -1, 4, 3,
                      {wr(9'h010), wr(9'h120), EV_R, EV_0}, 0, 1);
        vecs[10] = mk(4, {8'hA5,8'h01,8'h07,8'hF8,32'h0}, -1, 0, 0, {4{EV_0}}, 0, 0);

        repeat (3) @(posedge writeClk);
        #1;
        check("rst_fifoDataIn", 32'(fifoDataIn), 32'd0);
        check("rst_strobes", {29'd0, fifoWriteEn, fifoCommit, fifoRollback}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_okCount", 32'(okCount), 32'd0);
        check("rst_dropCount", 32'(dropCount), 32'd0);
        reset = 1'b0;
        idle(2);

        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < vecs[v].nexp; k++) expQ.push_back(vecs[v].ev[k]);
            for (int i = 0; i < vecs[v].n; i++)
                sendByte(vecs[v].b[i], i == vecs[v].feIdx, i == vecs[v].afIdx, 1);
            expOk += vecs[v].dOk;
            expDrop += vecs[v].dDrop;
            idle(4);
            checkSettled($sformatf("vec%0d", v));
            $display("vec %0d: %0d bytes, okCount=%0d dropCount=%0d", v, vecs[v].n, okCount, dropCount);
        end

        // Maximum-length payload: 64 bytes of 0x01, checksum 0x80.
        sendByte(8'hA5, 1'b0, 1'b0, 1);
        sendByte(8'h40, 1'b0, 1'b0, 1);
        for (int i = 0; i < 64; i++) begin
            expQ.push_back(wr({i == 63, 8'h01}));
            sendByte(8'h01, 1'b0, 1'b0, 0);
        end
        expQ.push_back(EV_C);
        sendByte(8'h80, 1'b0, 1'b0, 0);
        expOk++;
        idle(4);
        checkSettled("maxlen");
        $display("maxlen: 64-byte packet, okCount=%0d", okCount);

        // Back-to-back bytes; the SOF landing in the COMMIT cycle must be ignored.
        expQ.push_back(wr(9'h107));
        expQ.push_back(EV_C);
        sendByte(8'hA5, 1'b0, 1'b0, 0);
        sendByte(8'h01, 1'b0, 1'b0, 0);
        sendByte(8'h07, 1'b0, 1'b0, 0);
        sendByte(8'hF8, 1'b0, 1'b0, 0);
        sendByte(8'hA5, 1'b0, 1'b0, 0);
        sendByte(8'h01, 1'b0, 1'b0, 0);
        sendByte(8'h07, 1'b0, 1'b0, 0);
        sendByte(8'hF8, 1'b0, 1'b0, 0);
        expOk++;
        idle(4);
        checkSettled("commit_discard");
        $display("commit_discard: okCount=%0d", okCount);

        // Stalled packet.
        expQ.push_back(wr(9'h001));
        sendByte(8'hA5, 1'b0, 1'b0, 1);
        sendByte(8'h03, 1'b0, 1'b0, 1);
        sendByte(8'h01, 1'b0, 1'b0, 0);
        startRb = rollbackSeen;
`ifdef PKT_TIMEOUT_EN
        expQ.push_back(EV_R);
        waited = 0;
        while (rollbackSeen == startRb && waited < 150) begin
            idle(1);
            waited++;
        end
        check("timeout_rollback_seen", 32'(rollbackSeen - startRb), 32'd1);
        if ((lastRollbackCycle - lastRxCycle) < 100 || (lastRollbackCycle - lastRxCycle) > 102) begin
            checks++;
            errors++;
            $display("FAIL timeout_delay: got %0d cycles expected 100..102", lastRollbackCycle - lastRxCycle);
        end else begin
            checks++;
        end
        expDrop++;
        idle(4);
        checkSettled("timeout");
        $display("timeout: rollback %0d cycles after last byte", lastRollbackCycle - lastRxCycle);
        expQ.push_back(wr(9'h001));
        sendByte(8'hA5, 1'b0, 1'b0, 1);
        sendByte(8'h03, 1'b0, 1'b0, 1);
        sendByte(8'h01, 1'b0, 1'b0, 2);
`else
        waited = 0;
        idle(1000);
        check("stall_no_rollback", 32'(rollbackSeen - startRb), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_queue_empty", 32'(expQ.size()), 32'd0);
        $display("stall: no timeout after 1000 cycles, busy=%0d", busy);
`endif

        // Reset mid-packet abandons the packet without a rollback.
        reset = 1'b1;
        idle(2);
        check("midrst_strobes", {29'd0, fifoWriteEn, fifoCommit, fifoRollback}, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        expOk = 0;
        expDrop = 0;
        idle(3);
        checkSettled("after_reset");
        expQ.push_back(wr(9'h107));
        expQ.push_back(EV_C);
        sendByte(8'hA5, 1'b0, 1'b0, 1);
        sendByte(8'h01, 1'b0, 1'b0, 1);
        sendByte(8'h07, 1'b0, 1'b0, 1);
        sendByte(8'hF8, 1'b0, 1'b0, 1);
        expOk = 1;
        idle(4);
        checkSettled("post_reset_pkt");
        $display("post_reset_pkt: okCount=%0d dropCount=%0d", okCount, dropCount);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
